// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO input conditioning path.
package gpio_ctrl_pkg;

    localparam int unsigned GPIO_NUM         = 256;
    localparam int unsigned GPIO_SYNC_STAGES = 2;
    localparam int unsigned GPIO_FILT_CNT_W  = 8;
    localparam int unsigned GPIO_PRESCALE_W  = 16;

    // Per-pin filter action decoded each cycle.
    typedef enum logic [1:0] {
        FILT_BYPASS  = 2'd0,  // filter disabled: follow sync directly
        FILT_RESTART = 2'd1,  // sync agrees with output: discard partial count
        FILT_TICK    = 2'd2,  // mismatch on a sample tick: count or accept
        FILT_HOLD    = 2'd3   // mismatch between ticks: keep state
    } filt_act_e;

endpackage : gpio_ctrl_pkg

// File: rtl/gpio_ctrl_filter_bit.sv
// One pin's glitch filter: a new level must persist threshold+1 sample ticks.
module gpio_ctrl_filter_bit
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = GPIO_FILT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             enable,
    input  logic             tick,
    input  logic [CNT_W-1:0] threshold,
    output logic             q
);

    logic [CNT_W-1:0] cnt_q;
    filt_act_e        act_c;

    // Decode which rule applies this cycle.
    always_comb begin
        act_c = FILT_HOLD;
        if (!enable) begin
            act_c = FILT_BYPASS;
        end else if (sync == q) begin
            act_c = FILT_RESTART;
        end else if (tick) begin
            act_c = FILT_TICK;
        end
    end

    // Filtered level and saturating stability counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (act_c)
                FILT_BYPASS: begin
                    q     <= sync;
                    cnt_q <= '0;
                end
                FILT_RESTART: begin
                    cnt_q <= '0;
                end
                FILT_TICK: begin
                    if (cnt_q >= threshold) begin
                        q     <= sync;
                        cnt_q <= '0;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : gpio_ctrl_filter_bit

// File: rtl/gpio_ctrl_in_filter.sv
// Pad input synchroniser plus per-pin prescaled glitch filter feeding the
// edge detector and input-data status register.
module gpio_ctrl_in_filter
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned NUM_GPIO    = GPIO_NUM,
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int unsigned CNT_W       = GPIO_FILT_CNT_W,
    parameter int unsigned PRESCALE_W  = GPIO_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_GPIO-1:0]   gpio_in_raw,
    input  logic [NUM_GPIO-1:0]   filter_enable,
    input  logic [CNT_W-1:0]      filter_threshold,
    input  logic [PRESCALE_W-1:0] filter_prescale,
    output logic [NUM_GPIO-1:0]   gpio_in_sync,
    output logic [NUM_GPIO-1:0]   gpio_in_data
);

    logic [NUM_GPIO-1:0]   sync_q [SYNC_STAGES];
    logic [PRESCALE_W-1:0] pcnt_q;
    logic                  tick;

    // Multi-flop synchroniser chain for every pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in_raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign gpio_in_sync = sync_q[SYNC_STAGES-1];

    // A >= compare so a prescale lowered below the running count ticks at once.
    assign tick = (pcnt_q >= filter_prescale);

    // Shared sample-tick prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PRESCALE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_ctrl_filter_bit #(
            .CNT_W (CNT_W)
        ) u_filt (
            .clk       (clk),
            .rst_n     (rst_n),
            .sync      (sync_q[SYNC_STAGES-1][i]),
            .enable    (filter_enable[i]),
            .tick      (tick),
            .threshold (filter_threshold),
            .q         (gpio_in_data[i])
        );
    end

endmodule : gpio_ctrl_in_filter

// File: tb/tb_gpio_ctrl_in_filter.sv
// Scoreboard bench for gpio_ctrl_in_filter against a pin-level reference model.
module tb_gpio_ctrl_in_filter;

    localparam int N  = 256;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic [7:0]   thr;
    logic [15:0]  pre;
    logic [N-1:0] sync_o;
    logic [N-1:0] data_o;

    typedef struct {
        bit [N-1:0] sync;
        bit [N-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: raw history, cycles since last tick, per-pin level and run length.
    bit [N-1:0] m_hist [SS];
    int         m_since;
    bit [N-1:0] m_q;
    int         m_run [N];

    always #5 clk = ~clk;

    gpio_ctrl_in_filter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gpio_in_raw      (raw),
        .filter_enable    (en),
        .filter_threshold (thr),
        .filter_prescale  (pre),
        .gpio_in_sync     (sync_o),
        .gpio_in_data     (data_o)
    );

    // What the next clock edge should produce from the inputs now applied.
    task automatic model_edge();
        bit [N-1:0] seen;
        bit         sample;
        exp_t       e;
        if (!rst_n) begin
            for (int s = 0; s < SS; s++) m_hist[s] = '0;
            m_since = 0;
            m_q     = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            seen   = m_hist[SS-1];
            sample = (m_since >= int'(pre));
            m_since = sample ? 0 : m_since + 1;
            for (int s = SS-1; s > 0; s--) m_hist[s] = m_hist[s-1];
            m_hist[0] = raw;
            for (int i = 0; i < N; i++) begin
                if (!en[i]) begin
                    m_q[i]   = seen[i];
                    m_run[i] = 0;
                end else if (seen[i] == m_q[i]) begin
                    m_run[i] = 0;
                end else if (sample) begin
                    // Accept once the mismatch has been seen on threshold+1 ticks.
                    if (m_run[i] >= int'(thr)) begin
                        m_q[i]   = seen[i];
                        m_run[i] = 0;
                    end else if (m_run[i] < 255) begin
                        m_run[i] = m_run[i] + 1;
                    end
                end
            end
        end
        e.sync = m_hist[SS-1];
        e.data = m_q;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    // Monitor: one output pair per edge, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors += 2;
                if (sync_o !== e.sync) begin
                    miscompares++;
                    $display("FAIL sync t=%0t got=%h want=%h", $time, sync_o, e.sync);
                end
                if (data_o !== e.data) begin
                    miscompares++;
                    $display("FAIL data t=%0t got=%h want=%h", $time, data_o, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit [N-1:0] m;
        int         lat;
        rst_n = 1'b0;
        raw   = '1;
        en    = '0;
        thr   = 8'd0;
        pre   = 16'd0;
        @(negedge clk);

        // Reset held with pads high.
        cycle(3);
        rst_n = 1'b1;
        raw   = '0;
        cycle(5);

        // Bypass path.
        raw[5] = 1'b1;
        cycle(5);

        // Threshold 3 step latency on pin 40.
        en  = '1;
        thr = 8'd3;
        pre = 16'd0;
        raw = '0;
        cycle(10);
        raw[40] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1);
            if (data_o[40] && lat == 0) lat = k;
        end
        vectors++;
        if (lat != 6) begin
            miscompares++;
            $display("FAIL step_latency got=%0d want=6", lat);
        end

        // Glitch of 3 cycles rejected, 4-cycle pulse passes.
        raw[40] = 1'b0;
        cycle(10);
        raw[40] = 1'b1;
        cycle(3);
        raw[40] = 1'b0;
        cycle(10);
        raw[40] = 1'b1;
        cycle(4);
        raw[40] = 1'b0;
        cycle(12);

        // Prescaled sampling: step accepted, 9-cycle pulse rejected.
        pre = 16'd9;
        thr = 8'd1;
        raw[7] = 1'b1;
        cycle(40);
        raw[7] = 1'b0;
        cycle(40);
        raw[7] = 1'b1;
        cycle(9);
        raw[7] = 1'b0;
        cycle(40);

        // Disable mid-count, then re-enable.
        pre = 16'd0;
        thr = 8'd10;
        raw[9] = 1'b1;
        cycle(5);
        en[9] = 1'b0;
        cycle(3);
        en[9] = 1'b1;
        cycle(3);

        // Reset in the middle of a count.
        raw[11] = 1'b1;
        cycle(6);
        rst_n = 1'b0;
        cycle(1);
        rst_n = 1'b1;
        cycle(20);

        // Prescale lowered below the running count.
        pre = 16'd20;
        thr = 8'd0;
        raw[12] = 1'b1;
        cycle(10);
        pre = 16'd2;
        cycle(8);

        // Threshold lowered mid-count.
        pre = 16'd0;
        thr = 8'd20;
        raw[13] = 1'b1;
        cycle(6);
        thr = 8'd2;
        cycle(4);

        // Maximum threshold: counter reaches all-ones before accepting.
        thr = 8'd255;
        raw[14] = 1'b1;
        cycle(262);

        // Randomised traffic with sparse pad toggles.
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                for (int w = 0; w < N/32; w++) en[w*32 +: 32] = $urandom | $urandom;
                thr = 8'($urandom_range(0, 6));
                pre = 16'($urandom_range(0, 4));
            end
            for (int w = 0; w < N/32; w++) m[w*32 +: 32] = $urandom & $urandom & $urandom;
            raw   = raw ^ m;
            rst_n = ($urandom_range(0, 199) != 0);
            cycle(1);
        end
        rst_n = 1'b1;
        cycle(4);

        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_gpio_ctrl_in_filter
